// File: rtl/inst_queue_if.sv
// Fetch/issue handshake bundle for the instruction queue.
// The queue takes the slave side; the fetch unit and issuer together
// form the master side.
interface inst_queue_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    // Control
    logic             flush;

    // Fetch (write) side
    logic             fetch_wen;
    logic [31:0]      fetch_inst;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_next;
    logic             iq_isfull;

    // Issue (read) side
    logic             issue_req;
    logic [31:0]      iq_inst;
    logic [31:0]      iq_pc;
    logic [31:0]      iq_pc_next;
    logic             iq_rvalid;
    logic [PTR_W:0]   iq_count;

    modport master (
        output flush,
        output fetch_wen, fetch_inst, fetch_pc, fetch_pc_next,
        input  iq_isfull,
        output issue_req,
        input  iq_inst, iq_pc, iq_pc_next, iq_rvalid, iq_count
    );

    modport slave (
        input  flush,
        input  fetch_wen, fetch_inst, fetch_pc, fetch_pc_next,
        output iq_isfull,
        input  issue_req,
        output iq_inst, iq_pc, iq_pc_next, iq_rvalid, iq_count
    );
endinterface

// File: rtl/inst_queue.sv
// Circular-buffer instruction queue between fetch and issue.
// Show-ahead head: the oldest entry is driven combinationally from storage
// at rd_ptr. Full/empty come from the occupancy counter, so the pointers can
// wrap freely and equal pointers are never ambiguous.
module inst_queue #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    inst_queue_if.slave iq
);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;

    // Handshake qualification uses the pre-edge occupancy, so a push into a
    // full queue is dropped even if a pop frees a slot in the same cycle, and
    // a pop from an empty queue never sees a same-cycle push (no bypass).
    always_comb begin
        is_full  = (count == FULL_CNT);
        is_empty = (count == '0);
        push     = iq.fetch_wen & ~is_full;
        pop      = iq.issue_req & ~is_empty;
    end

    // Pointer and occupancy state; reset and flush both collapse to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (iq.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage has no reset; a flushed or reset cycle must not write so
    // the dropped instruction never lands in a slot.
    always_ff @(posedge clk) begin
        if (!rst && !iq.flush && push) begin
            mem[wr_ptr] <= '{inst:    iq.fetch_inst,
                             pc:      iq.fetch_pc,
                             pc_next: iq.fetch_pc_next};
        end
    end

    // Head is read straight out of storage; consumers qualify with iq_rvalid.
    assign iq.iq_inst    = mem[rd_ptr].inst;
    assign iq.iq_pc      = mem[rd_ptr].pc;
    assign iq.iq_pc_next = mem[rd_ptr].pc_next;
    assign iq.iq_rvalid  = ~is_empty;
    assign iq.iq_isfull  = is_full;
    assign iq.iq_count   = count;

endmodule

// File: tb/tb_inst_queue.sv
// Directed plus randomized bench for inst_queue against a queue-based model.
module tb_inst_queue;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcn;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    ent_t model[$];

    inst_queue_if #(.DEPTH(DEPTH)) iq();
    inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .iq(iq));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic req, input logic fl,
                         input logic [31:0] inst, input logic [31:0] pc);
        iq.fetch_wen     = wen;
        iq.issue_req     = req;
        iq.flush         = fl;
        iq.fetch_inst    = inst;
        iq.fetch_pc      = pc;
        iq.fetch_pc_next = pc + 32'd4;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":count"}, 32'(iq.iq_count), 32'(model.size()));
        chk({ctx, ":rvalid"}, 32'(iq.iq_rvalid), 32'(model.size() != 0));
        chk({ctx, ":isfull"}, 32'(iq.iq_isfull), 32'(model.size() == DEPTH));
        if (model.size() != 0) begin
            chk({ctx, ":inst"}, iq.iq_inst, model[0].inst);
            chk({ctx, ":pc"}, iq.iq_pc, model[0].pc);
            chk({ctx, ":pc_next"}, iq.iq_pc_next, model[0].pcn);
        end
    endtask

    // One clock: advance the model from the pre-edge inputs, clock the DUT,
    // then compare everything observable.
    task automatic step(input string ctx);
        bit   full = (model.size() == DEPTH);
        bit   psh  = iq.fetch_wen && !full;
        bit   pp   = iq.issue_req && (model.size() != 0);
        ent_t e;
        if (rst || iq.flush) begin
            model.delete();
        end else begin
            if (pp) e = model.pop_front();
            if (psh) begin
                e.inst = iq.fetch_inst;
                e.pc   = iq.fetch_pc;
                e.pcn  = iq.fetch_pc_next;
                model.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset then idle, including a pop request while empty
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
        chk("reset_count", 32'(iq.iq_count), 32'd0);
        chk("reset_rvalid", 32'(iq.iq_rvalid), 32'd0);
        chk("reset_isfull", 32'(iq.iq_isfull), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step("pop_empty");
        chk("pop_empty_count", 32'(iq.iq_count), 32'd0);

        // Fill to full, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h13 + 32'(i), 32'h6000_0000 + 32'(4 * i));
            step("fill");
        end
        chk("fill_isfull", 32'(iq.iq_isfull), 32'd1);
        chk("fill_count", 32'(iq.iq_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_inst", iq.iq_inst, 32'h13 + 32'(i));
            chk("drain_pc", iq.iq_pc, 32'h6000_0000 + 32'(4 * i));
            chk("drain_pcn", iq.iq_pc_next, 32'h6000_0004 + 32'(4 * i));
            drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            step("drain");
        end
        chk("drained_rvalid", 32'(iq.iq_rvalid), 32'd0);

        // Full boundary: simultaneous push/pop drops the push
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i), 32'h6000_0200 + 32'(4 * i));
            step("refill");
        end
        drive(1'b1, 1'b1, 1'b0, 32'hAAAA_0000, 32'h6000_0300);
        step("full_both");
        chk("full_both_count", 32'(iq.iq_count), 32'd7);
        chk("full_both_head", iq.iq_inst, 32'h101);
        drive(1'b1, 1'b0, 1'b0, 32'hAAAA_0000, 32'h6000_0300);
        step("full_retry");
        chk("full_retry_count", 32'(iq.iq_count), 32'd8);
        chk("full_retry_isfull", 32'(iq.iq_isfull), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            step("drain2");
        end

        // Empty boundary: no bypass, push lands, pop ignored
        drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h6000_0400);
        step("empty_both");
        chk("empty_both_count", 32'(iq.iq_count), 32'd1);
        chk("empty_both_rvalid", 32'(iq.iq_rvalid), 32'd1);
        chk("empty_both_inst", iq.iq_inst, 32'hDEAD_BEEF);

        // Streaming at occupancy 3 across pointer wraps
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h4000 + 32'(i), 32'h6000_0500 + 32'(4 * i));
            step("prime");
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h5000 + 32'(i), 32'h6000_0600 + 32'(4 * i));
            step("stream");
            chk("stream_count", 32'(iq.iq_count), 32'd3);
        end

        // Flush beats same-cycle push and pop
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h7000 + 32'(i), 32'h6000_0700 + 32'(4 * i));
            step("to_five");
        end
        chk("pre_flush_count", 32'(iq.iq_count), 32'd5);
        drive(1'b1, 1'b1, 1'b1, 32'hBAD0_0000, 32'h6000_0800);
        step("flush");
        chk("flush_count", 32'(iq.iq_count), 32'd0);
        chk("flush_rvalid", 32'(iq.iq_rvalid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h6000_0100);
        step("post_flush");
        chk("post_flush_pc", iq.iq_pc, 32'h6000_0100);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            int phase = (i / 100) % 3;
            logic wen = (phase == 0) ? ($urandom_range(0, 3) != 0) :
                        (phase == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1;
            logic req = (phase == 0) ? ($urandom_range(0, 3) == 0) :
                        (phase == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1;
            logic fl  = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 150) == 0);
            drive(wen, req, fl, $urandom, $urandom);
            step("rand");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular-buffer instruction queue between the fetch unit (write side) and the issuer (read side). Fetch pushes {inst, pc, pc_next} triples.
- The head entry is presented combinationally (show-ahead) on iq_inst/iq_pc/iq_pc_next with iq_rvalid. The issuer pops it by asserting issue_req.
- A flush from the ROB/branch-resolution path empties the queue in one cycle.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all entries (mispredict/redirect)
- fetch_wen  input  1  push request from fetch
- fetch_inst  input  32  instruction word to push
- fetch_pc  input  32  PC of pushed instruction
- fetch_pc_next  input  32  predicted next PC of pushed instruction
- iq_isfull  output  1  queue holds DEPTH entries; push will be dropped
- issue_req  input  1  pop request from issuer, combinational from iq_rvalid
- iq_inst  output  32  head instruction
- iq_pc  output  32  head PC
- iq_pc_next  output  32  head predicted next PC
- iq_rvalid  output  1  head entry valid (queue non-empty)
- iq_count  output  PTR_W+1  current occupancy 0..DEPTH

Behaviour:
- State: storage arrays inst/pc/pc_next[DEPTH], rd_ptr and wr_ptr (PTR_W bits), count (PTR_W+1 bits). All are updated on posedge clk only.
- Reset (rst=1 at a clock edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Therefore iq_rvalid=0, iq_isfull=0, iq_count=0.
  - Storage contents are don't-care. iq_inst/iq_pc/iq_pc_next show the stale entry at rd_ptr; they are qualified only by iq_rvalid.
- Derived outputs:
  - iq_rvalid = (count != 0).
  - iq_isfull = (count == DEPTH).
  - iq_count = count.
  - Head outputs = storage[rd_ptr]. This is a combinational read with zero latency from pointer update.
- Push:
  - push = fetch_wen & ~iq_isfull.
  - On push: write the triple at wr_ptr, then wr_ptr = wr_ptr+1 (mod DEPTH, natural wrap).
  - fetch_wen while full is silently dropped; fetch must hold the request until ~iq_isfull.
- Pop:
  - pop = issue_req & iq_rvalid.
  - On pop: rd_ptr = rd_ptr+1 (mod DEPTH).
  - issue_req while empty is ignored.
- Count update:
  - push only: +1.
  - pop only: −1.
  - Both or neither: unchanged.
- Simultaneous push and pop:
  - Not full, not empty: both take effect, count unchanged.
  - Full: the pop occurs, the push is dropped (fullness is judged on the pre-edge count), count = DEPTH−1.
  - Empty: no bypass. The push occurs, the pop is ignored, count = 1. The new entry appears on the head outputs the following cycle.
- Flush:
  - Flush at an edge sets rd_ptr=0, wr_ptr=0, count=0.
  - It overrides any same-cycle push and pop; the pushed instruction is lost.
  - Outputs show empty the cycle after.
- Priority: rst > flush > push/pop.
- Latency:
  - Push at edge N is visible on the head (if the queue was empty) from N+1.
  - Pop at edge N advances the head from N+1.
  - Sustained throughput is 1 push + 1 pop per cycle.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Wrap-around: pointers wrap DEPTH−1 → 0 with no bubble. Full and empty are distinguished by count, not by pointer equality.
- Reset or flush mid-stream discards everything; there is no partial-flush support.

Test Plan:
- Reset then idle: rst=1 for 1 cycle → iq_rvalid=0, iq_isfull=0, iq_count=0. issue_req=1 while empty → count stays 0.
- Fill and drain order, DEPTH=8: push 8 entries inst=0x00000013+i, pc=0x60000000+4i, pc_next=pc+4 → iq_isfull=1, count=8. Pop 8 → heads appear in order i=0..7, then iq_rvalid=0.
- Full boundary: with count=8, fetch_wen=1 and issue_req=1 in the same cycle → pop of entry 0, push dropped, count=7. Fetch re-asserts the push next cycle → accepted, count=8.
- Empty-simultaneous: with count=0, fetch_wen=1 (inst 0xDEADBEEF) and issue_req=1 → count=1 and no pop. Next cycle iq_rvalid=1, iq_inst=0xDEADBEEF.
- Wrap-around streaming: 20 cycles of concurrent push/pop with count held at 3 → pointers wrap at least twice, data stays ordered, count stays 3.
- Flush precedence: count=5, and flush=1 together with fetch_wen=1 and issue_req=1 → next cycle count=0, iq_rvalid=0. A subsequent push of pc=0x60000100 is the head 1 cycle later.
